entrada_tempo: RTL and testbench
================================

// Module: entrada_tempo
// PURPOSE
//   Time-entry and run controller that drives the M:SS countdown counter
//   (inputs uni_sec/dez_sec/min, load, enable; output zero).
//   Digits are keyed in microwave-style: each new digit shifts in from the right.
//   On start, a one-cycle load pulse is issued, then enable is gated until the
//   counter reports zero.
//   Pause/resume and clear are supported.
// PARAMETERS
//   DIG_W         4  width of each BCD digit
//   SEC_TENS_MAX  5  largest legal tens-of-seconds digit at start
// PORTS
//   clk        in   1      system clock (same clock as the countdown counter)
//   reset      in   1      synchronous, active-high reset
//   key_valid  in   1      one-cycle strobe: key_code is valid
//   key_code   in   DIG_W  keypad digit; 0-9 legal, 10-15 illegal
//   start      in   1      one-cycle strobe: start, pause or resume
//   clear      in   1      one-cycle strobe: abort and empty the buffer
//   zero       in   1      counter all-digits-zero flag (combinational in counter)
//   uni_sec    out  DIG_W  buffered seconds units -> counter
//   dez_sec    out  DIG_W  buffered seconds tens  -> counter
//   min        out  DIG_W  buffered minutes       -> counter
//   load       out  1      counter load; high exactly one cycle per start
//   enable     out  1      counter count enable
//   done       out  1      high while in DONE
//   err        out  1      one-cycle pulse on a rejected key or start
// BEHAVIOUR
//   Reset: state=IDLE; uni_sec=dez_sec=min=0; digit count=0; load=enable=done=err=0.
//   States: IDLE, ENTRY, LOAD, RUN, PAUSE, DONE.
//   load=(state==LOAD).
//   enable=(state==RUN)&~zero; combinational, so the counter never wraps past 0:00.
//   done=(state==DONE).
//   Priority in every state: reset > clear > start > key_valid.
//     clear: go to IDLE, zero the buffer and digit count.
//   Digit shift on a legal key: min<=dez_sec; dez_sec<=uni_sec; uni_sec<=key_code;
//     digit count += 1 (saturates at 3).
//   IDLE:
//     legal key -> shift, go to ENTRY.
//     illegal key -> err.
//     start -> err, stay in IDLE.
//   ENTRY:
//     legal key with count<3 -> shift.
//     legal key with count==3 -> ignored, buffer unchanged, no err.
//     illegal key -> err, buffer unchanged.
//     start with dez_sec>SEC_TENS_MAX, or buffer==0:00 -> err, stay in ENTRY.
//     other start -> LOAD.
//   LOAD:
//     unconditionally -> RUN next cycle.
//     Counter captures the buffer on the edge that ends LOAD.
//   RUN:
//     zero==1 -> DONE.
//     start -> PAUSE (zero is checked first).
//     Keys ignored, no err.
//   PAUSE:
//     start -> RUN.
//     Keys ignored.
//     enable=0.
//   DONE:
//     start -> IDLE with buffer cleared.
//     legal key -> buffer cleared, the key is shifted in as the first digit, go to ENTRY.
//   Buffer outputs are registered and stable from LOAD until leaving DONE.
//   Latency: start seen at edge N -> load high in cycle N+1 -> enable high from N+2.
//   err asserts the cycle after the offending strobe and lasts one cycle.
// TESTING
//   T1 reset mid-RUN -> next cycle: IDLE, all outputs 0, enable=0.
//   T2 keys 1,3,0 then start -> min=1, dez=3, uni=0; load pulses 1 cycle;
//     enable rises 1 cycle after load; stays high to zero; then DONE, enable=0.
//   T3 keys 1,2,3,4 -> buffer stays 1:23 (4th key dropped).
//     Key 11 -> err pulse, buffer unchanged.
//   T4 keys 7,5 then start -> dez=7 is illegal: err pulse, no load, state stays ENTRY.
//     Start with empty 0:00 -> err.
//   T5 in RUN, start -> enable=0 and counter holds; start again -> enable resumes.
//     clear+start in the same cycle -> IDLE.
//   T6 zero asserted with enable high -> enable drops combinationally in the same cycle.
//     Key 4 in DONE -> ENTRY with 0:04.

Source files
------------

// File: rtl/entrada_tempo.sv
`default_nettype none
// ============================================================================
// entrada_tempo : microwave-style M:SS time entry and run control for the
//                 countdown counter (load pulse, gated enable, pause, clear).
// Revision 1.0
// ============================================================================
module entrada_tempo #(
  parameter int unsigned DIG_W        = 4,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [DIG_W-1:0] key_code,
  input  logic             start,
  input  logic             clear,
  input  logic             zero,
  output logic [DIG_W-1:0] uni_sec,
  output logic [DIG_W-1:0] dez_sec,
  output logic [DIG_W-1:0] min,
  output logic             load,
  output logic             enable,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [DIG_W-1:0] uni_q, uni_d;
  logic [DIG_W-1:0] dez_q, dez_d;
  logic [DIG_W-1:0] min_q, min_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic w_key_legal;
  logic w_buf_zero;
  logic w_tens_bad;

  assign w_key_legal = (key_code <= DIG_W'(9));
  assign w_buf_zero  = (uni_q == '0) && (dez_q == '0) && (min_q == '0);
  assign w_tens_bad  = (dez_q > DIG_W'(SEC_TENS_MAX));

  always_comb begin
    state_d = state_q;
    uni_d   = uni_q;
    dez_d   = dez_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      uni_d   = '0;
      dez_d   = '0;
      min_d   = '0;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_d = 1'b1;
          end else if (key_valid) begin
            if (w_key_legal) begin
              min_d   = dez_q;
              dez_d   = uni_q;
              uni_d   = key_code;
              cnt_d   = cnt_q + 2'd1;
              state_d = S_ENTRY;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        S_ENTRY: begin
          if (start) begin
            if (w_tens_bad || w_buf_zero) begin
              err_d = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end else if (key_valid) begin
            if (!w_key_legal) begin
              err_d = 1'b1;
            end else if (cnt_q != 2'd3) begin
              min_d = dez_q;
              dez_d = uni_q;
              uni_d = key_code;
              cnt_d = cnt_q + 2'd1;
            end
          end
        end

        S_LOAD: state_d = S_RUN;

        // Reaching zero wins over a simultaneous pause request.
        S_RUN: begin
          if (zero) begin
            state_d = S_DONE;
          end else if (start) begin
            state_d = S_PAUSE;
          end
        end

        S_PAUSE: begin
          if (start) begin
            state_d = S_RUN;
          end
        end

        S_DONE: begin
          if (start) begin
            state_d = S_IDLE;
            uni_d   = '0;
            dez_d   = '0;
            min_d   = '0;
            cnt_d   = 2'd0;
          end else if (key_valid && w_key_legal) begin
            state_d = S_ENTRY;
            uni_d   = key_code;
            dez_d   = '0;
            min_d   = '0;
            cnt_d   = 2'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
          uni_d   = '0;
          dez_d   = '0;
          min_d   = '0;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      uni_q   <= '0;
      dez_q   <= '0;
      min_q   <= '0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uni_q   <= uni_d;
      dez_q   <= dez_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // enable is combinational on zero so the counter stops exactly at 0:00.
  assign load    = (state_q == S_LOAD);
  assign enable  = (state_q == S_RUN) & ~zero;
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign uni_sec = uni_q;
  assign dez_sec = dez_q;
  assign min     = min_q;

endmodule
`default_nettype wire

// File: tb/tb_entrada_tempo.sv
`default_nettype none
// ============================================================================
// tb_entrada_tempo : self-checking bench with an M:SS countdown counter model
//                    and a load scoreboard.
// Revision 1.0
// ============================================================================
module tb_entrada_tempo;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       start;
  logic       clear;
  logic       zero;
  logic [3:0] uni_sec;
  logic [3:0] dez_sec;
  logic [3:0] min;
  logic       load;
  logic       enable;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];

  logic [3:0] cm, cd, cu;

  entrada_tempo #(.DIG_W(4), .SEC_TENS_MAX(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_code  (key_code),
    .start     (start),
    .clear     (clear),
    .zero      (zero),
    .uni_sec   (uni_sec),
    .dez_sec   (dez_sec),
    .min       (min),
    .load      (load),
    .enable    (enable),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Countdown counter model fed by the controller.
  always @(posedge clk) begin
    if (reset) begin
      cm <= 4'd0; cd <= 4'd0; cu <= 4'd0;
    end else if (load) begin
      cm <= min; cd <= dez_sec; cu <= uni_sec;
    end else if (enable) begin
      if (cu != 4'd0) begin
        cu <= cu - 4'd1;
      end else begin
        cu <= 4'd9;
        if (cd != 4'd0) begin
          cd <= cd - 4'd1;
        end else begin
          cd <= 4'd5;
          cm <= cm - 4'd1;
        end
      end
    end
  end
  assign zero = (cm == 4'd0) && (cd == 4'd0) && (cu == 4'd0);

  // Load scoreboard: every load pulse must match the next expected buffer.
  always begin
    @(posedge clk);
    #1;
    if (load === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL load_unexpected: got load with buffer %h, none expected", {min, dez_sec, uni_sec});
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({min, dez_sec, uni_sec} !== e) begin
          bad++;
          $display("FAIL load_buffer: got %h want %h", {min, dez_sec, uni_sec}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    total++;
    if ({min, dez_sec, uni_sec, load, enable, done, err} !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0000", {min, dez_sec, uni_sec, load, enable, done, err});
    end
  endtask

  task automatic test_run();
    int n;
    int guard;
    bit zchk;
    key(4'd1); key(4'd3); key(4'd0);
    total++;
    if ({min, dez_sec, uni_sec} !== 12'h130) begin
      bad++; $display("FAIL run_entry: got %h want 130", {min, dez_sec, uni_sec});
    end
    exp_q.push_back(12'h130);
    press_start();
    total++;
    if ({load, enable} !== 2'b10) begin
      bad++; $display("FAIL run_load_cycle: got load/en %b want 10", {load, enable});
    end
    tick();
    total++;
    if ({load, enable} !== 2'b01) begin
      bad++; $display("FAIL run_enable_rise: got load/en %b want 01", {load, enable});
    end
    n = 0; guard = 0; zchk = 0;
    while (done !== 1'b1 && guard < 300) begin
      if (enable === 1'b1) n++;
      if (zero && !zchk) begin
        zchk = 1;
        total++;
        if (enable !== 1'b0) begin
          bad++; $display("FAIL run_zero_drop: got enable %b want 0", enable);
        end
      end
      tick();
      guard++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL run_done_timeout: got done %b want 1", done);
    end
    total++;
    if (n != 90) begin
      bad++; $display("FAIL run_enable_cycles: got %0d want 90", n);
    end
    total++;
    if ({enable, min, dez_sec, uni_sec} !== 13'h0130) begin
      bad++; $display("FAIL run_done_hold: got en/buf %h want 0130", {enable, min, dez_sec, uni_sec});
    end
    key(4'd4);
    total++;
    if ({done, min, dez_sec, uni_sec} !== 13'h0004) begin
      bad++; $display("FAIL done_key: got done/buf %h want 0004", {done, min, dez_sec, uni_sec});
    end
    do_clear();
  endtask

  task automatic test_entry_limits();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    total++;
    if ({err, min, dez_sec, uni_sec} !== 13'h0123) begin
      bad++; $display("FAIL entry_fourth_key: got err/buf %h want 0123", {err, min, dez_sec, uni_sec});
    end
    key(4'd11);
    total++;
    if ({err, min, dez_sec, uni_sec} !== 13'h1123) begin
      bad++; $display("FAIL entry_illegal_key: got err/buf %h want 1123", {err, min, dez_sec, uni_sec});
    end
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL entry_err_width: got err %b want 0", err);
    end
    do_clear();
    key(4'd15);
    total++;
    if ({err, min, dez_sec, uni_sec} !== 13'h1000) begin
      bad++; $display("FAIL idle_illegal_key: got err/buf %h want 1000", {err, min, dez_sec, uni_sec});
    end
    do_clear();
  endtask

  task automatic test_start_errors();
    int guard;
    press_start();
    total++;
    if ({err, load} !== 2'b10) begin
      bad++; $display("FAIL idle_start: got err/load %b want 10", {err, load});
    end
    key(4'd7); key(4'd5);
    press_start();
    total++;
    if ({err, load} !== 2'b10) begin
      bad++; $display("FAIL tens_too_big: got err/load %b want 10", {err, load});
    end
    tick();
    total++;
    if ({err, load} !== 2'b00) begin
      bad++; $display("FAIL tens_after: got err/load %b want 00", {err, load});
    end
    key(4'd9);
    total++;
    if ({min, dez_sec, uni_sec} !== 12'h759) begin
      bad++; $display("FAIL stays_entry: got %h want 759", {min, dez_sec, uni_sec});
    end
    do_clear();
    key(4'd0);
    press_start();
    total++;
    if ({err, load} !== 2'b10) begin
      bad++; $display("FAIL empty_start: got err/load %b want 10", {err, load});
    end
    do_clear();
    key(4'd5); key(4'd9);
    exp_q.push_back(12'h059);
    press_start();
    total++;
    if ({err, load} !== 2'b01) begin
      bad++; $display("FAIL tens_max_start: got err/load %b want 01", {err, load});
    end
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL tens_max_done_timeout: got done %b want 1", done);
    end
    do_clear();
  endtask

  task automatic test_pause();
    logic [11:0] snap;
    key(4'd2); key(4'd0);
    exp_q.push_back(12'h020);
    press_start();
    repeat (3) tick();
    press_start();
    total++;
    if (enable !== 1'b0) begin
      bad++; $display("FAIL pause_enable: got %b want 0", enable);
    end
    snap = {cm, cd, cu};
    repeat (3) tick();
    total++;
    if ({enable, cm, cd, cu} !== {1'b0, snap}) begin
      bad++; $display("FAIL pause_hold: got en/cnt %h want %h", {enable, cm, cd, cu}, {1'b0, snap});
    end
    press_start();
    total++;
    if (enable !== 1'b1) begin
      bad++; $display("FAIL resume_enable: got %b want 1", enable);
    end
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    total++;
    if ({load, enable, done, err, min, dez_sec, uni_sec} !== 16'h0) begin
      bad++; $display("FAIL clear_start: got %h want 0000", {load, enable, done, err, min, dez_sec, uni_sec});
    end
    press_start();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL clear_to_idle: got err %b want 1", err);
    end
  endtask

  task automatic test_reset_mid_run();
    key(4'd5);
    exp_q.push_back(12'h005);
    press_start();
    repeat (2) tick();
    total++;
    if (enable !== 1'b1) begin
      bad++; $display("FAIL midrun_enable: got %b want 1", enable);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({min, dez_sec, uni_sec, load, enable, done, err} !== 16'h0) begin
      bad++; $display("FAIL midrun_reset: got %h want 0000", {min, dez_sec, uni_sec, load, enable, done, err});
    end
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0; start = 1'b0; clear = 1'b0;
    test_reset();
    test_run();
    test_entry_limits();
    test_start_errors();
    test_pause();
    test_reset_mid_run();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_loads: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
